button_shaper: RTL

BUTTON_SHAPER -- requirements
Module: button_shaper

---
 rtl/button_shaper_if.sv | 26 ++
 rtl/button_shaper.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/button_shaper_if.sv
// button_shaper_if: groups the pushbutton/switch inputs and the load-strobe
// outputs of button_shaper. The master side drives the raw button and switch
// levels and observes the strobe. The slave side is the shaper itself.
interface button_shaper_if;
  logic       btn_in;    // raw button level, active-low, asynchronous to CLK
  logic [3:0] sw_in;     // raw player switch value, asynchronous to CLK
  logic       sig_load;  // one-cycle load strobe
  logic [3:0] data_out;  // switch value captured for the strobe
  logic       busy;      // high while the FSM is not idle

  modport master (
    output btn_in,
    output sw_in,
    input  sig_load,
    input  data_out,
    input  busy
  );

  modport slave (
    input  btn_in,
    input  sw_in,
    output sig_load,
    output data_out,
    output busy
  );
endinterface

// File: rtl/button_shaper.sv
// button_shaper: turns a bouncy active-low pushbutton into a single one-cycle
// load strobe, and captures the synchronized switch value with that strobe.
//
// Both raw inputs pass through two-flop synchronizers first. A five-state FSM
// (IDLE, DEB_PRESS, PULSE, HELD, DEB_RELEASE) then debounces press and release
// with a 16-bit counter. sig_load is a registered output that is high exactly
// while the FSM sits in PULSE.
//
// Optional feature: define BUTTON_SHAPER_REPEAT_EN to enable auto-repeat
// while the button stays held. The first repeat comes after REPEAT_DELAY
// cycles in HELD, and later repeats come every REPEAT_PERIOD cycles. Each
// repeat captures a fresh switch value. Without the macro, HELD is left only
// by a release, and the repeat parameters do not exist.
module button_shaper #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
`ifdef BUTTON_SHAPER_REPEAT_EN
  , parameter int unsigned REPEAT_DELAY  = 1024
  , parameter int unsigned REPEAT_PERIOD = 256
`endif
) (
  input  logic           CLK,
  input  logic           RST,
  button_shaper_if.slave sh
);

  // Terminal count values for the debounce counter.
  localparam logic [15:0] DEB_LAST = 16'(DEBOUNCE_CYCLES - 1);
`ifdef BUTTON_SHAPER_REPEAT_EN
  localparam logic [15:0] DLY_LAST = 16'(REPEAT_DELAY - 1);
  localparam logic [15:0] PER_LAST = 16'(REPEAT_PERIOD - 1);
`endif

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    DEB_PRESS   = 3'd1,
    PULSE       = 3'd2,
    HELD        = 3'd3,
    DEB_RELEASE = 3'd4
  } state_t;

  // Synchronizer stages. The button resets to "released" (1), so a button
  // that is held through reset still needs a full debounce afterwards.
  logic       btn_meta_q;
  logic       btn_sync_q;
  logic [3:0] sw_meta_q;
  logic [3:0] sw_sync_q;

  // FSM state and registered outputs.
  state_t      state_q;
  logic [15:0] cnt_q;
  logic        sig_load_q;
  logic [3:0]  data_q;
`ifdef BUTTON_SHAPER_REPEAT_EN
  // Set once the first auto-repeat of a hold has fired. It selects
  // REPEAT_PERIOD instead of REPEAT_DELAY as the next repeat interval.
  logic        rep_q;
`endif

  // Two-flop synchronizers for the asynchronous button and switch inputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      btn_meta_q <= 1'b1;
      btn_sync_q <= 1'b1;
      sw_meta_q  <= 4'b0000;
      sw_sync_q  <= 4'b0000;
    end else begin
      btn_meta_q <= sh.btn_in;
      btn_sync_q <= btn_meta_q;
      sw_meta_q  <= sh.sw_in;
      sw_sync_q  <= sw_meta_q;
    end
  end

  // Debounce FSM with registered strobe and switch capture.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      cnt_q      <= 16'd0;
      sig_load_q <= 1'b0;
      data_q     <= 4'b0000;
`ifdef BUTTON_SHAPER_REPEAT_EN
      rep_q      <= 1'b0;
`endif
    end else begin
      // The strobe defaults low. Only a transition into PULSE raises it, so
      // it can never stay high for two cycles.
      sig_load_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!btn_sync_q) begin
            state_q <= DEB_PRESS;
            cnt_q   <= 16'd0;
          end
        end

        DEB_PRESS: begin
          if (btn_sync_q) begin
            // Too short a low pulse: reject as a glitch.
            state_q <= IDLE;
            cnt_q   <= 16'd0;
          end else if (cnt_q == DEB_LAST) begin
            state_q    <= PULSE;
            cnt_q      <= 16'd0;
            sig_load_q <= 1'b1;
            data_q     <= sw_sync_q;
`ifdef BUTTON_SHAPER_REPEAT_EN
            rep_q      <= 1'b0;
`endif
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end

        PULSE: begin
          // Leave after one cycle whatever the button does.
          state_q <= HELD;
          cnt_q   <= 16'd0;
        end

        HELD: begin
          if (btn_sync_q) begin
            // A release beats a repeat that is due in the same cycle.
            state_q <= DEB_RELEASE;
            cnt_q   <= 16'd0;
          end
`ifdef BUTTON_SHAPER_REPEAT_EN
          else if (cnt_q == (rep_q ? PER_LAST : DLY_LAST)) begin
            state_q    <= PULSE;
            cnt_q      <= 16'd0;
            sig_load_q <= 1'b1;
            data_q     <= sw_sync_q;
            rep_q      <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
`endif
        end

        DEB_RELEASE: begin
          if (!btn_sync_q) begin
            // Release bounce: go back to HELD without a new strobe.
            state_q <= HELD;
            cnt_q   <= 16'd0;
          end else if (cnt_q == DEB_LAST) begin
            state_q <= IDLE;
            cnt_q   <= 16'd0;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end

        default: begin
          // Unused encodings recover to IDLE with the strobe low.
          state_q    <= IDLE;
          cnt_q      <= 16'd0;
          sig_load_q <= 1'b0;
        end
      endcase
    end
  end

  assign sh.sig_load = sig_load_q;
  assign sh.data_out = data_q;
  assign sh.busy     = (state_q != IDLE);

endmodule
